// File: rtl/rhs2116_init_seq.sv
// Power-up sequencer and SPI-port owner for the RHS2116 front end.
// Define RHS2116_INIT_VERIFY_EN to add the chip-ID check with retry/error handling.
module rhs2116_init_seq #(
  parameter int          NUM_WRITES = 24,
  parameter int          TBL_AW     = 5,
  parameter logic [15:0] CHIP_ID    = 16'h0020,
  parameter int          MAX_RETRY  = 3
) (
  input  logic              clk_spi,
  input  logic              rst_n,
  input  logic              init_start,
  input  logic              abort,
  output logic              cmd_valid,
  output logic [31:0]       cmd_data,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              spi_sel,
  output logic              sample_enable,
  input  logic              sampler_idle,
  output logic              busy,
  output logic              init_done,
  output logic              init_err
);

`ifdef RHS2116_INIT_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  localparam logic [31:0] CMD_CLEAR   = 32'h6A00_0000;
  localparam logic [31:0] CMD_READ_ID = {2'b11, 6'b0, 8'hFF, 16'h0000};
  localparam logic [31:0] CMD_DUMMY   = CMD_READ_ID;

  localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(NUM_WRITES - 1);

  localparam int              RCW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RCW-1:0]  RETRY_MAX = RCW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_TBL_RD,
    S_TBL_WAIT,
    S_WR,
    S_FLUSH,
    S_VERIFY,
    S_HANDOFF,
    S_RUN,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [31:0]       cmd_data_q, cmd_data_d;
  logic              pend_q, pend_d;          // frame accepted, response not yet seen
  logic              abort_pend_q, abort_pend_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic [RCW-1:0]    retry_q, retry_d;

  logic frame_state;
  logic frame_done;

  // The ID check only looks at the low half of the MISO word.
  logic unused_rsp_hi;
  assign unused_rsp_hi = ^rsp_data[31:16];

  assign frame_state = (state_q == S_CLR)   || (state_q == S_WR) ||
                       (state_q == S_FLUSH) || (state_q == S_VERIFY);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_data_d   = cmd_data_q;
    pend_d       = pend_q;
    abort_pend_d = abort_pend_q;
    idx_d        = idx_q;
    flush_cnt_d  = flush_cnt_q;
    retry_d      = retry_q;
    frame_done   = 1'b0;

    // Shared single-frame handshake; an unaccepted request is withdrawn on abort,
    // an accepted one runs to its response before the abort is honoured.
    if (frame_state) begin
      if (cmd_valid_q) begin
        if (cmd_ready) begin
          cmd_valid_d  = 1'b0;
          pend_d       = 1'b1;
          abort_pend_d = abort;
        end else if (abort) begin
          cmd_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end else if (pend_q) begin
        if (rsp_valid) begin
          pend_d       = 1'b0;
          abort_pend_d = 1'b0;
          if (abort || abort_pend_q) state_d = S_IDLE;
          else                       frame_done = 1'b1;
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (init_start && !abort) begin
          state_d     = S_CLR;
          retry_d     = '0;
          cmd_valid_d = 1'b1;
          cmd_data_d  = CMD_CLEAR;
        end
      end
      S_CLR: begin
        if (frame_done) begin
          state_d = S_TBL_RD;
          idx_d   = '0;
        end
      end
      S_TBL_RD: begin
        state_d = abort ? S_IDLE : S_TBL_WAIT;
      end
      S_TBL_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_WR;
          cmd_valid_d = 1'b1;
          cmd_data_d  = {2'b10, 6'b0, tbl_data};
        end
      end
      S_WR: begin
        if (frame_done) begin
          if (idx_q == LAST_IDX) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
            cmd_valid_d = 1'b1;
            cmd_data_d  = CMD_DUMMY;
          end else begin
            state_d = S_TBL_RD;
            idx_d   = idx_q + TBL_AW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (frame_done) begin
          if (flush_cnt_q == 2'd1) begin
            flush_cnt_d = '0;
            if (VERIFY_EN) begin
              state_d     = S_VERIFY;
              cmd_valid_d = 1'b1;
              cmd_data_d  = CMD_READ_ID;
            end else begin
              state_d = S_HANDOFF;
            end
          end else begin
            flush_cnt_d = flush_cnt_q + 2'd1;
            cmd_valid_d = 1'b1;
            cmd_data_d  = CMD_DUMMY;
          end
        end
      end
      S_VERIFY: begin
        // The ID read result emerges on the third response (READ + two dummies).
        if (frame_done) begin
          if (flush_cnt_q == 2'd2) begin
            flush_cnt_d = '0;
            if (rsp_data[15:0] == CHIP_ID) begin
              state_d = S_HANDOFF;
            end else if (retry_q < RETRY_MAX) begin
              retry_d     = retry_q + RCW'(1);
              state_d     = S_CLR;
              cmd_valid_d = 1'b1;
              cmd_data_d  = CMD_CLEAR;
            end else begin
              state_d = S_ERROR;
            end
          end else begin
            flush_cnt_d = flush_cnt_q + 2'd1;
            cmd_valid_d = 1'b1;
            cmd_data_d  = CMD_DUMMY;
          end
        end
      end
      S_HANDOFF: begin
        state_d = abort ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (abort) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (sampler_idle) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (init_start) begin
          state_d     = S_CLR;
          retry_d     = '0;
          cmd_valid_d = 1'b1;
          cmd_data_d  = CMD_CLEAR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_spi) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_data_q   <= '0;
      pend_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      idx_q        <= '0;
      flush_cnt_q  <= '0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_data_q   <= cmd_data_d;
      pend_q       <= pend_d;
      abort_pend_q <= abort_pend_d;
      idx_q        <= idx_d;
      flush_cnt_q  <= flush_cnt_d;
      retry_q      <= retry_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_data      = cmd_data_q;
  assign tbl_addr      = idx_q;
  assign spi_sel       = (state_q == S_HANDOFF) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign sample_enable = (state_q == S_RUN);
  assign busy          = !((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_ERROR));
  assign init_done     = (state_q == S_RUN);
  assign init_err      = VERIFY_EN && (state_q == S_ERROR);

endmodule

// File: tb/tb_rhs2116_init_seq.sv
// Scoreboard bench for rhs2116_init_seq: a transceiver model answers each frame
// 40 cycles after acceptance; a monitor pops expected MOSI words on every accept.
module tb_rhs2116_init_seq;

  localparam int TBL_AW  = 5;
  localparam int RSP_LAT = 40;

  logic              clk_spi;
  logic              rst_n;
  logic              init_start;
  logic              abort;
  logic              cmd_valid;
  logic [31:0]       cmd_data;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [TBL_AW-1:0] tbl_addr;
  logic [23:0]       tbl_data;
  logic              spi_sel;
  logic              sample_enable;
  logic              sampler_idle;
  logic              busy;
  logic              init_done;
  logic              init_err;

  rhs2116_init_seq #(
    .NUM_WRITES (3),
    .TBL_AW     (TBL_AW),
    .CHIP_ID    (16'h0020),
    .MAX_RETRY  (3)
  ) dut (
    .clk_spi       (clk_spi),
    .rst_n         (rst_n),
    .init_start    (init_start),
    .abort         (abort),
    .cmd_valid     (cmd_valid),
    .cmd_data      (cmd_data),
    .cmd_ready     (cmd_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .tbl_addr      (tbl_addr),
    .tbl_data      (tbl_data),
    .spi_sel       (spi_sel),
    .sample_enable (sample_enable),
    .sampler_idle  (sampler_idle),
    .busy          (busy),
    .init_done     (init_done),
    .init_err      (init_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  logic [15:0] id_val = 16'h0020;
  logic [31:0] exp_q[$];
  logic [23:0] tbl_mem [0:31];

  initial begin
    clk_spi = 1'b0;
    forever #5 clk_spi = ~clk_spi;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed MOSI words for one complete pass with the 3-entry table.
  task automatic push_seq();
    exp_q.push_back(32'h6A00_0000);
    exp_q.push_back(32'h8020_1234);
    exp_q.push_back(32'h8021_0001);
    exp_q.push_back(32'h8026_FFFF);
    exp_q.push_back(32'hC0FF_0000);
    exp_q.push_back(32'hC0FF_0000);
`ifdef RHS2116_INIT_VERIFY_EN
    repeat (3) exp_q.push_back(32'hC0FF_0000);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk_spi); init_start = 1'b1;
    @(negedge clk_spi); init_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_data"},  cmd_data, 32'd0);
    check({tag, "_tbl_addr"},  32'(tbl_addr), 32'd0);
    check({tag, "_spi_sel"},   32'(spi_sel), 32'd0);
    check({tag, "_sample_en"}, 32'(sample_enable), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'd0);
    check({tag, "_init_err"},  32'(init_err), 32'd0);
  endtask

  task automatic wait_sel(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_spi); #2;
      if (spi_sel) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_acc(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_spi); #3;
      if (acc_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  // Synchronous table ROM: data follows the address by one clock.
  initial begin
    for (int i = 0; i < 32; i++) tbl_mem[i] = 24'h0;
    tbl_mem[0] = 24'h20_1234;
    tbl_mem[1] = 24'h21_0001;
    tbl_mem[2] = 24'h26_FFFF;
    tbl_data = 24'h0;
    forever begin
      @(posedge clk_spi);
      tbl_data <= tbl_mem[tbl_addr];
    end
  end

  // Transceiver model: one-cycle rsp_valid RSP_LAT cycles after each accept.
  initial begin
    int cnt;
    cnt = 0;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    forever begin
      @(negedge clk_spi); #1;
      rsp_valid = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = {16'hA5C3, id_val};
          end
        end
        if (cmd_valid && cmd_ready) cnt = RSP_LAT;
      end
    end
  end

  // Monitor: every accepted frame is compared with the head of the scoreboard.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk_spi); #1;
      if (rst_n && cmd_valid && cmd_ready) begin
        acc_cnt++;
        check("sb_frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("frame_word", cmd_data, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int bad;
    int base;

    rst_n        = 1'b0;
    init_start   = 1'b0;
    abort        = 1'b0;
    cmd_ready    = 1'b1;
    sampler_idle = 1'b1;
    repeat (3) @(negedge clk_spi);
    rst_n = 1'b1;
    #2;
    check_reset_outputs("reset");

    // init_start while abort is high must be ignored.
    @(negedge clk_spi); abort = 1'b1; init_start = 1'b1;
    @(negedge clk_spi); abort = 1'b0; init_start = 1'b0;
    #2;
    check("ignored_start_cmd_valid", 32'(cmd_valid), 32'd0);
    check("ignored_start_busy", 32'(busy), 32'd0);

    // Full sequence to hand-off.
    base = acc_cnt;
    push_seq();
    pulse_start();
    #2;
    check("start_latency_cmd_valid", 32'(cmd_valid), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    wait_sel(3000, ok);
    check("handoff_reached", 32'(ok), 32'd1);
    check("handoff_sample_en", 32'(sample_enable), 32'd0);
    @(negedge clk_spi); #2;
    check("run_sample_en", 32'(sample_enable), 32'd1);
    check("run_spi_sel", 32'(spi_sel), 32'd1);
    check("run_init_done", 32'(init_done), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_frames_left", 32'(exp_q.size()), 32'd0);
`ifdef RHS2116_INIT_VERIFY_EN
    check("run_frame_count", 32'(acc_cnt - base), 32'd9);
`else
    check("run_frame_count", 32'(acc_cnt - base), 32'd6);
`endif

    // Abort in RUN with a busy sampler: drain until it goes idle.
    @(negedge clk_spi); abort = 1'b1; sampler_idle = 1'b0;
    @(negedge clk_spi); abort = 1'b0;
    #2;
    check("drain_sample_en", 32'(sample_enable), 32'd0);
    check("drain_spi_sel", 32'(spi_sel), 32'd1);
    check("drain_init_done", 32'(init_done), 32'd0);
    bad = 0;
    repeat (19) begin
      @(negedge clk_spi); #2;
      if (spi_sel !== 1'b1 || sample_enable !== 1'b0) bad++;
    end
    check("drain_hold_cycles_bad", 32'(bad), 32'd0);
    @(negedge clk_spi); sampler_idle = 1'b1;
    @(negedge clk_spi); #2;
    check("drain_exit_spi_sel", 32'(spi_sel), 32'd0);
    check("drain_exit_busy", 32'(busy), 32'd0);

    // cmd_ready stalled 10 cycles, then abort mid-frame during the second WRITE.
    base = acc_cnt;
    exp_q.push_back(32'h6A00_0000);
    exp_q.push_back(32'h8020_1234);
    exp_q.push_back(32'h8021_0001);
    @(negedge clk_spi); cmd_ready = 1'b0;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (cmd_valid !== 1'b1 || cmd_data !== 32'h6A00_0000) bad++;
      @(negedge clk_spi);
    end
    check("stall_hold_cycles_bad", 32'(bad), 32'd0);
    check("stall_no_accept", 32'(acc_cnt - base), 32'd0);
    cmd_ready = 1'b1;
    wait_acc(base + 3, 1000, ok);
    check("second_write_accepted", 32'(ok), 32'd1);
    repeat (10) @(negedge clk_spi);
    abort = 1'b1;
    repeat (5) @(negedge clk_spi);
    abort = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk_spi); #2;
      if (cmd_valid) bad++;
    end
    check("abort_wr_no_cmd_valid", 32'(bad), 32'd0);
    check("abort_wr_busy", 32'(busy), 32'd0);
    check("abort_wr_init_done", 32'(init_done), 32'd0);
    check("abort_wr_frame_count", 32'(acc_cnt - base), 32'd3);
    check("abort_wr_frames_left", 32'(exp_q.size()), 32'd0);

`ifdef RHS2116_INIT_VERIFY_EN
    // Chip ID never matches: 1 + MAX_RETRY full passes, then ERROR.
    id_val = 16'h0000;
    repeat (4) push_seq();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_spi); #2;
      if (init_err) begin ok = 1'b1; break; end
    end
    check("retry_error_reached", 32'(ok), 32'd1);
    check("retry_spi_sel", 32'(spi_sel), 32'd0);
    check("retry_busy", 32'(busy), 32'd0);
    check("retry_frames_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk_spi); abort = 1'b1;
    @(negedge clk_spi); abort = 1'b0;
    #2;
    check("error_abort_init_err", 32'(init_err), 32'd0);
    id_val = 16'h0020;
`endif

    // One-cycle reset while FLUSH has a frame outstanding, then a clean restart.
    base = acc_cnt;
    exp_q.push_back(32'h6A00_0000);
    exp_q.push_back(32'h8020_1234);
    exp_q.push_back(32'h8021_0001);
    exp_q.push_back(32'h8026_FFFF);
    exp_q.push_back(32'hC0FF_0000);
    pulse_start();
    wait_acc(base + 5, 1000, ok);
    check("flush_frame_accepted", 32'(ok), 32'd1);
    repeat (10) @(negedge clk_spi);
    rst_n = 1'b0;
    @(negedge clk_spi); rst_n = 1'b1;
    #2;
    check_reset_outputs("midflush_reset");
    repeat (50) @(negedge clk_spi);
    check("midflush_quiet", 32'(acc_cnt - base), 32'd5);
    push_seq();
    pulse_start();
    wait_sel(3000, ok);
    check("restart_handoff", 32'(ok), 32'd1);
    @(negedge clk_spi); #2;
    check("restart_sample_en", 32'(sample_enable), 32'd1);
    check("restart_init_done", 32'(init_done), 32'd1);
    check("restart_frames_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rhs2116_init_seq.md
# rhs2116_init_seq

Power-up sequencer and SPI-port owner for the RHS2116 front end. It drives a single-frame 32-bit SPI transceiver through a command/response handshake and runs this sequence:
- CLEAR;
- register WRITEs fetched from an external table;
- pipeline flush;
- optional chip-ID check.

It then hands the SPI pins to the CONVERT sampler (`spi_master_rhs2116`) by driving `spi_sel` and `sample_enable`. On `abort` it takes the pins back only once the sampler is idle.

## Interface
Parameters:
- `NUM_WRITES`, 24: number of table entries issued as WRITE commands (≥1).
- `TBL_AW`, 5: table address width; `NUM_WRITES` ≤ 2^`TBL_AW`.
- `CHIP_ID`, 16'h0020: expected `rsp_data[15:0]` for READ(255).
- `MAX_RETRY`, 3: full-sequence retries after an ID mismatch before error.

Ports:
- `clk_spi` in 1: single clock; every port is synchronous to it.
- `rst_n` in 1: synchronous, active-low reset.
- `init_start` in 1: one-cycle pulse; ignored unless in IDLE or ERROR.
- `abort` in 1: level; requests a return to IDLE.
- `cmd_valid` out 1: frame request to the transceiver.
- `cmd_data` out 32: frame MOSI word.
- `cmd_ready` in 1: transceiver accepts the frame.
- `rsp_valid` in 1: one-cycle pulse when the frame's MISO word is complete.
- `rsp_data` in 32: MISO word.
- `tbl_addr` out `TBL_AW`: table read address.
- `tbl_data` in 24: {reg[7:0], data[15:0]}; valid one cycle after `tbl_addr`.
- `spi_sel` out 1: 0 = this block owns the SPI pins, 1 = sampler owns them.
- `sample_enable` out 1: drives the sampler's `enable`.
- `sampler_idle` in 1: sampler has CS high and is not mid-frame.
- `busy`, `init_done`, `init_err` out 1 each: status.

## Operation
Command encodings:
- CLEAR = 32'h6A00_0000.
- WRITE(R,D) = {2'b10, 6'b0, R, D}.
- READ(R) = {2'b11, 6'b0, R, 16'h0}.
- DUMMY = READ(8'hFF).

Frame rule:
- At most one frame is outstanding.
- `cmd_valid` rises with `cmd_data` and holds both stable until the `cmd_valid&cmd_ready` cycle.
- The block then waits for `rsp_valid`.
- `cmd_valid` is never re-asserted before that `rsp_valid`.

States:
- IDLE: on `init_start` go to CLR; clear `init_err`; retry_cnt=0.
- CLR: send CLEAR; on its rsp go to TBL_RD with idx=0.
- TBL_RD: `tbl_addr`=idx; go to TBL_WAIT.
- TBL_WAIT: latch `tbl_data`; go to WR.
- WR: send WRITE(reg, data). On rsp: if idx==NUM_WRITES-1 go to FLUSH with flush_cnt=0; else idx+1 and go to TBL_RD.
- FLUSH: send 2 DUMMY frames, then go to VERIFY (VERIFY_EN build) or HANDOFF.
- VERIFY: send READ(255), then 2 DUMMY frames. Compare the third rsp's `[15:0]` against `CHIP_ID`.
  - Match: go to HANDOFF.
  - Mismatch with retry_cnt<MAX_RETRY: retry_cnt+1, go to CLR.
  - Mismatch otherwise: go to ERROR.
- HANDOFF: `spi_sel`=1 this cycle; `sample_enable`=1 next cycle; go to RUN.
- RUN: `init_done`=1; hold `spi_sel`=1 and `sample_enable`=1.
- DRAIN: `sample_enable`=0 and `spi_sel` held at 1. On `sampler_idle`=1: `spi_sel`=0 and go to IDLE.
- ERROR: `init_err`=1; `init_start` goes to CLR with retry_cnt=0.

Abort handling:
- In CLR, TBL_*, WR, FLUSH or VERIFY: `abort` takes effect at the next frame boundary, i.e. the rsp of any outstanding frame. A `cmd_valid` not yet accepted is withdrawn immediately. Go to IDLE.
- In RUN or HANDOFF: go to DRAIN.
- In ERROR: go to IDLE and clear `init_err`.
- `init_start` while `abort`=1 is ignored.

Status outputs:
- `busy`=1 in every state except IDLE, RUN and ERROR.
- `init_done` clears on leaving RUN.

## Timing
- Reset values:
  - Outputs: `cmd_valid`=0, `cmd_data`=0, `tbl_addr`=0, `spi_sel`=0, `sample_enable`=0, `busy`=0, `init_done`=0, `init_err`=0.
  - State: IDLE; idx, retry_cnt and flush_cnt all 0.
  - Reset mid-frame abandons the frame silently; the transceiver is reset by the same `rst_n`.
- Latencies:
  - `init_start` to `cmd_valid`=1 (CLEAR): 1 cycle.
  - `rsp_valid` to next `cmd_valid`: 1 cycle within CLR/FLUSH/VERIFY; 3 cycles into WR via TBL_RD and TBL_WAIT.
- Frame count: a successful sequence sends exactly 1+NUM_WRITES+2 frames, +3 with VERIFY_EN.
- Ordering: `spi_sel` never changes while `cmd_valid`=1 or while a frame is outstanding. `sample_enable`=1 implies `spi_sel`=1 on the previous cycle.
- Simultaneity: if `rsp_valid` and `abort` arrive in the same cycle, the response is consumed and the state goes to IDLE.

## Configuration
- `RHS2116_INIT_VERIFY_EN` defined: VERIFY state, `CHIP_ID` compare and retry logic are present.
- Not defined: FLUSH goes directly to HANDOFF. `init_err` is tied 0 and ERROR is unreachable; `MAX_RETRY` and `CHIP_ID` are unused.

## Test plan
- NUM_WRITES=3, table {(0x20,0x1234),(0x21,0x0001),(0x26,0xFFFF)}, transceiver model with rsp 40 cycles after accept, `init_start`. Required frames in order: 6A000000, 80201234, 80210001, 8026FFFF, C0FF0000 ×2, C0FF0000 ×3 (READ(255) + 2 DUMMY). ID rsp [15:0]=0x0020 -> `spi_sel`=1, then `sample_enable`=1 one cycle later, `init_done`=1.
- ID rsp=0x0000 on every attempt, MAX_RETRY=3 -> 4 CLEARs total, then `init_err`=1, `spi_sel`=0, `busy`=0.
- `cmd_ready` held low 10 cycles -> `cmd_data` stable throughout and exactly one frame accepted.
- `abort` during the second WR, mid-frame -> no further `cmd_valid` after that rsp; IDLE; `init_done`=0.
- In RUN, `abort` with `sampler_idle`=0 for 20 cycles -> `sample_enable`=0 next cycle, `spi_sel` stays 1 until `sampler_idle`=1, then 0.
- `rst_n`=0 for one cycle during FLUSH -> all outputs at reset values next cycle; a new `init_start` restarts from CLEAR.
